// File: rtl/vga_scanout_if.sv
// Pixel-stream and display bundle between a PPU producer and vga_scanout.
// Combinational wiring only; it adds no latency.
// The producer holds stb_i with data_i until it sees ack_o.
interface vga_scanout_if #(
  parameter int FIFO_AW = 4
);
  logic [7:0]       data_i;
  logic             stb_i;
  logic             ack_o;
  logic [5:0]       rgb_o;
  logic             hsync_o;
  logic             vsync_o;
  logic             de_o;
  logic             sync_o;
  logic             underrun_clr;
  logic [7:0]       underrun_cnt;
  logic [FIFO_AW:0] fifo_level;

  // Producer / test side.
  modport master (
    output data_i, stb_i, underrun_clr,
    input  ack_o, rgb_o, hsync_o, vsync_o, de_o, sync_o, underrun_cnt, fifo_level
  );

  // Scanout side.
  modport slave (
    input  data_i, stb_i, underrun_clr,
    output ack_o, rgb_o, hsync_o, vsync_o, de_o, sync_o, underrun_cnt, fifo_level
  );
endinterface

// File: rtl/vga_scanout.sv
// RGB222 pixel FIFO plus VGA timing generator; one byte is popped per active pixel.
// Push to ack / level: 1 clk. Counters to rgb/hsync/vsync/de/sync: 1 clk, all aligned.
// Full FIFO withholds ack so stb_i stays pending; empty FIFO in active video outputs black and counts an underrun.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FIFO_AW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  vga_scanout_if.slave  io_vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DEPTH   = 1 << FIFO_AW;

  // Raster position.
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [31:0]   w_h32;
  logic [31:0]   w_v32;

  // FIFO state.
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp;
  logic [FIFO_AW-1:0] r_rp;
  logic [FIFO_AW:0]   r_level;

  // Registered outputs.
  logic       r_ack;
  logic [5:0] r_rgb;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_de;
  logic       r_sync;
  logic [7:0] r_und;

  logic w_de;
  logic w_hs_n;
  logic w_vs_n;
  logic w_frame;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_underrun;

  // Compare the counters at 32 bits so porch sums that reach the total cannot overflow.
  assign w_h32 = 32'(r_h);
  assign w_v32 = 32'(r_v);

  assign w_de    = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
  assign w_hs_n  = !((w_h32 >= H_ACTIVE + H_FP) && (w_h32 < H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_n  = !((w_v32 >= V_ACTIVE + V_FP) && (w_v32 < V_ACTIVE + V_FP + V_SYNC));
  assign w_frame = (w_h32 == 32'd0) && (w_v32 == V_ACTIVE);

  // Full test uses the level before the edge, so push and pop never collide on a full FIFO.
  // The ack term stops a second capture while the producer is still releasing stb_i.
  assign w_full     = (r_level == (FIFO_AW + 1)'(DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_push     = io_vga.stb_i && !r_ack && !w_full;
  assign w_pop      = w_de && !w_empty;
  assign w_underrun = w_de && w_empty;

  // Horizontal and vertical raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h32 == H_TOTAL - 1) begin
      r_h <= '0;
      if (w_v32 == V_TOTAL - 1) r_v <= '0;
      else                      r_v <= r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= io_vga.data_i;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + FIFO_AW'(1);
      if (w_pop)  r_rp <= r_rp + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (FIFO_AW + 1)'(1);
        2'b01:   r_level <= r_level - (FIFO_AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // One-cycle acknowledge following each capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ack <= 1'b0;
    else     r_ack <= w_push;
  end

  // Display outputs, all registered off the same counter state to stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_de    <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_rgb   <= w_pop ? r_mem[r_rp][7:2] : 6'd0;
      r_hsync <= w_hs_n;
      r_vsync <= w_vs_n;
      r_de    <= w_de;
      r_sync  <= w_frame;
    end
  end

  // Saturating starvation counter; clear wins over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_und <= '0;
    else if (io_vga.underrun_clr)            r_und <= '0;
    else if (w_underrun && r_und != 8'hFF)   r_und <= r_und + 8'd1;
  end

  assign io_vga.ack_o        = r_ack;
  assign io_vga.rgb_o        = r_rgb;
  assign io_vga.hsync_o      = r_hsync;
  assign io_vga.vsync_o      = r_vsync;
  assign io_vga.de_o         = r_de;
  assign io_vga.sync_o       = r_sync;
  assign io_vga.underrun_cnt = r_und;
  assign io_vga.fifo_level   = r_level;

endmodule
